// File: rtl/iq_pkg.sv
// Shared definitions for the I/Q modem blocks: widths, FSM states, sine table.
// Latency: n/a (package only).
// Backpressure: n/a.
package iq_pkg;

  localparam int DEF_DATA_W  = 24;
  localparam int DEF_PHASE_W = 8;

  localparam real PI = 3.14159265358979323846;

  typedef enum logic {IDLE, RUN} iq_state_e;

  // Accumulator width: full product plus log2(DECIM) growth bits, so a whole
  // block of worst-case products can never overflow.
  function automatic int acc_w(input int data_w, input int decim);
    return 2 * data_w + $clog2(decim);
  endfunction

  // Entry k of the carrier table: round((2^(data_w-1)-1) * sin(2*pi*k/2^phase_w)),
  // rounding half away from zero. Evaluated at elaboration only; data_w <= 32.
  function automatic int sine_entry(input int k, input int data_w, input int phase_w);
    real x;
    x = $itor((1 << (data_w - 1)) - 1) * $sin(2.0 * PI * $itor(k) / $itor(1 << phase_w));
    return $rtoi((x >= 0.0) ? (x + 0.5) : (x - 0.5));
  endfunction

endpackage

// File: rtl/iq_demod_if.sv
// Sample/control inputs and baseband/carrier outputs of the I/Q demodulator.
// Latency: n/a (signal bundle only).
// Backpressure: none; the sample stream is valid-only.
// master: drives enable, freq_tuning_word, y_in, y_valid; observes the results.
// slave : the demodulator itself.
interface iq_demod_if #(
  parameter int DATA_W  = iq_pkg::DEF_DATA_W,
  parameter int PHASE_W = iq_pkg::DEF_PHASE_W
);
  logic                       enable;
  logic [PHASE_W-1:0]         freq_tuning_word;
  logic signed [DATA_W-1:0]   y_in;
  logic                       y_valid;
  logic signed [DATA_W-1:0]   i_carrier;
  logic signed [DATA_W-1:0]   q_carrier;
  logic signed [2*DATA_W-1:0] i_out;
  logic signed [2*DATA_W-1:0] q_out;
  logic                       out_valid;

  modport master (
    output enable, freq_tuning_word, y_in, y_valid,
    input  i_carrier, q_carrier, i_out, q_out, out_valid
  );

  modport slave (
    input  enable, freq_tuning_word, y_in, y_valid,
    output i_carrier, q_carrier, i_out, q_out, out_valid
  );
endinterface

// File: rtl/iq_sine_lut.sv
// Dual-read registered sine ROM: one port for sin, one for cos addresses.
// Latency: 1 cycle from address to data.
// Backpressure: none; reads every cycle.
// Ports: clk, reset_n (sync, active-low), sin_addr_i/cos_addr_i (table index),
//        sin_o/cos_o (registered signed table values).
module iq_sine_lut import iq_pkg::*; #(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int PHASE_W = DEF_PHASE_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [PHASE_W-1:0]       sin_addr_i,
  input  logic [PHASE_W-1:0]       cos_addr_i,
  output logic signed [DATA_W-1:0] sin_o,
  output logic signed [DATA_W-1:0] cos_o
);
  localparam int DEPTH   = 1 << PHASE_W;
  localparam int QUARTER = DEPTH / 4;

  logic signed [DATA_W-1:0] rom [DEPTH];
  logic signed [DATA_W-1:0] sin_q;
  logic signed [DATA_W-1:0] cos_q;

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam logic signed [DATA_W-1:0] ENTRY = DATA_W'(sine_entry(k, DATA_W, PHASE_W));
    assign rom[k] = ENTRY;
  end

  // Reset presents the phase-0 carrier pair (cos = full scale, sin = 0).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sin_q <= rom[0];
      cos_q <= rom[QUARTER];
    end else begin
      sin_q <= rom[sin_addr_i];
      cos_q <= rom[cos_addr_i];
    end
  end

  assign sin_o = sin_q;
  assign cos_o = cos_q;
endmodule

// File: rtl/iq_demod.sv
// Coherent I/Q demodulator: mixes samples with a local quadrature carrier, integrate-and-dump by DECIM.
// Latency: out_valid 3 cycles after the DECIM-th accepted sample; one sample per cycle.
// Backpressure: none; enable low discards the partial block and any in-flight dump.
// Ports: clk, reset_n (sync, active-low), bus (iq_demod_if.slave: enable, freq_tuning_word,
//        y_in/y_valid in; i_carrier/q_carrier, i_out/q_out, out_valid out).
module iq_demod import iq_pkg::*; #(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int PHASE_W = DEF_PHASE_W,
  parameter int DECIM   = 16
) (
  input logic       clk,
  input logic       reset_n,
  iq_demod_if.slave bus
);
  localparam int PROD_W = 2 * DATA_W;
  localparam int SHIFT  = $clog2(DECIM);
  localparam int ACC_W  = acc_w(DATA_W, DECIM);
  localparam int CNT_W  = SHIFT;
  localparam logic [CNT_W-1:0]   LAST    = CNT_W'(DECIM - 1);
  localparam logic [PHASE_W-1:0] QUARTER = PHASE_W'(1) << (PHASE_W - 2);

  iq_state_e                 state_q, state_d;
  logic [PHASE_W-1:0]        phase_q, phase_d;
  logic signed [DATA_W-1:0]  y1_q, y1_d;
  logic                      v1_q, v1_d;
  logic signed [PROD_W-1:0]  pi_q, pi_d, pq_q, pq_d;
  logic                      v2_q, v2_d;
  logic signed [ACC_W-1:0]   acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic signed [PROD_W-1:0]  i_out_q, i_out_d, q_out_q, q_out_d;
  logic                      ov_q, ov_d;

  logic signed [DATA_W-1:0]  sin_car;
  logic signed [DATA_W-1:0]  cos_car;
  logic signed [ACC_W-1:0]   sum_i;
  logic signed [ACC_W-1:0]   sum_q;
  logic                      accept;

  // The ROM is addressed by the phase of the next sample, so its registered
  // output lines up with that sample one cycle after acceptance.
  iq_sine_lut #(
    .DATA_W  (DATA_W),
    .PHASE_W (PHASE_W)
  ) u_lut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sin_addr_i (phase_q),
    .cos_addr_i (phase_q + QUARTER),
    .sin_o      (sin_car),
    .cos_o      (cos_car)
  );

  assign accept = bus.enable && bus.y_valid;
  assign sum_i  = acc_i_q + ACC_W'(pi_q);
  assign sum_q  = acc_q_q + ACC_W'(pq_q);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    y1_d    = y1_q;
    v1_d    = 1'b0;
    pi_d    = pi_q;
    pq_d    = pq_q;
    v2_d    = 1'b0;
    acc_i_d = acc_i_q;
    acc_q_d = acc_q_q;
    cnt_d   = cnt_q;
    i_out_d = i_out_q;
    q_out_d = q_out_q;
    ov_d    = 1'b0;

    case (state_q)
      IDLE: if (bus.enable)  state_d = RUN;
      RUN:  if (!bus.enable) state_d = IDLE;
    endcase

    if (state_d == IDLE) begin
      // Valid bits already default low, which drops anything in flight.
      phase_d = '0;
      acc_i_d = '0;
      acc_q_d = '0;
      cnt_d   = '0;
    end else begin
      if (accept) begin
        phase_d = phase_q + bus.freq_tuning_word;
        y1_d    = bus.y_in;
        v1_d    = 1'b1;
      end
      if (v1_q) begin
        pi_d = PROD_W'(y1_q) * PROD_W'(cos_car);
        pq_d = PROD_W'(y1_q) * PROD_W'(sin_car);
        v2_d = 1'b1;
      end
      if (v2_q) begin
        if (cnt_q == LAST) begin
          // Arithmetic shift = average rounded toward -inf.
          i_out_d = PROD_W'(sum_i >>> SHIFT);
          q_out_d = PROD_W'(sum_q >>> SHIFT);
          ov_d    = 1'b1;
          acc_i_d = '0;
          acc_q_d = '0;
          cnt_d   = '0;
        end else begin
          acc_i_d = sum_i;
          acc_q_d = sum_q;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      phase_q <= '0;
      y1_q    <= '0;
      v1_q    <= 1'b0;
      pi_q    <= '0;
      pq_q    <= '0;
      v2_q    <= 1'b0;
      acc_i_q <= '0;
      acc_q_q <= '0;
      cnt_q   <= '0;
      i_out_q <= '0;
      q_out_q <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      y1_q    <= y1_d;
      v1_q    <= v1_d;
      pi_q    <= pi_d;
      pq_q    <= pq_d;
      v2_q    <= v2_d;
      acc_i_q <= acc_i_d;
      acc_q_q <= acc_q_d;
      cnt_q   <= cnt_d;
      i_out_q <= i_out_d;
      q_out_q <= q_out_d;
      ov_q    <= ov_d;
    end
  end

  assign bus.i_carrier = cos_car;
  assign bus.q_carrier = sin_car;
  assign bus.i_out     = i_out_q;
  assign bus.q_out     = q_out_q;
  assign bus.out_valid = ov_q;
endmodule

// File: tb/tb_iq_demod.sv
module tb_iq_demod;
  localparam int     DW  = 24;
  localparam int     PW  = 8;
  localparam int     DEC = 16;
  localparam int     SH  = 4;
  localparam longint AMP     = 64'sd8388607;
  localparam longint DC_Y    = 64'sd4194304;
  localparam longint DC_EXP  = 64'sd35184367894528;
  localparam longint EXT_Y   = -64'sd8388608;
  localparam longint EXT_EXP = -64'sd70368735789056;
  localparam longint TOL     = 64'sd1048576;

  logic clk = 1'b0;
  logic reset_n;

  iq_demod_if #(.DATA_W(DW), .PHASE_W(PW)) bus ();

  iq_demod #(.DATA_W(DW), .PHASE_W(PW), .DECIM(DEC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     due;
    longint i;
    longint q;
  } strobe_t;

  strobe_t sq[$];
  int      checks = 0;
  int      failures = 0;
  longint  lut [256];

  // Reference-model state (cycle t = inputs driven before the t-th posedge)
  int     t = 0;
  int     ph = 0;
  int     bcnt = 0;
  longint acc_i = 0, acc_q = 0;
  longint cur_i = 0, cur_q = 0;
  bit     prev_rst = 1'b1, prev_acc = 1'b0, idle1 = 1'b1, idle2 = 1'b1;
  int     prev_ph = 0;
  int     strobes = 0;
  longint obs_i = 0, obs_q = 0;
  int     strobe_cyc = 0, last_acc_cyc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // One cycle: check this cycle's outputs against the model, then drive inputs.
  task automatic step(input bit r, input bit en, input bit v, input longint y, input int ftw);
    bit exp_v;
    bit acc;
    @(negedge clk);
    t++;
    exp_v = 1'b0;
    if (sq.size() > 0 && sq[0].due == t) begin
      exp_v = 1'b1;
      cur_i = sq[0].i;
      cur_q = sq[0].q;
      void'(sq.pop_front());
    end
    chk("out_valid", 64'(bus.out_valid), 64'(exp_v));
    chk("i_out", 64'(bus.i_out), cur_i);
    chk("q_out", 64'(bus.q_out), cur_q);
    if (bus.out_valid === 1'b1) begin
      strobes++;
      obs_i = 64'(bus.i_out);
      obs_q = 64'(bus.q_out);
      strobe_cyc = t;
    end
    if (prev_rst) begin
      chk("i_carrier_reset", 64'(bus.i_carrier), AMP);
      chk("q_carrier_reset", 64'(bus.q_carrier), 64'sd0);
    end else if (prev_acc) begin
      chk("i_carrier", 64'(bus.i_carrier), lut[(prev_ph + 64) % 256]);
      chk("q_carrier", 64'(bus.q_carrier), lut[prev_ph]);
    end else if (idle1 && idle2) begin
      chk("i_carrier_idle", 64'(bus.i_carrier), lut[64]);
      chk("q_carrier_idle", 64'(bus.q_carrier), lut[0]);
    end

    reset_n              = r;
    bus.enable           = en;
    bus.y_valid          = v;
    bus.y_in             = y[DW-1:0];
    bus.freq_tuning_word = ftw[PW-1:0];

    acc      = r && en && v;
    idle2    = idle1;
    idle1    = !r || !en;
    prev_rst = !r;
    prev_acc = acc;
    prev_ph  = ph;
    if (!r || !en) begin
      while (sq.size() > 0 && sq[$].due > t) void'(sq.pop_back());
      ph = 0; bcnt = 0; acc_i = 0; acc_q = 0;
      if (!r) begin
        cur_i = 0;
        cur_q = 0;
      end
    end else if (acc) begin
      acc_i += y * lut[(ph + 64) % 256];
      acc_q += y * lut[ph];
      bcnt++;
      last_acc_cyc = t;
      if (bcnt == DEC) begin
        sq.push_back('{t + 3, acc_i >>> SH, acc_q >>> SH});
        bcnt = 0; acc_i = 0; acc_q = 0;
      end
      ph = (ph + ftw) % 256;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b1, 1'b0, 1'b0, 64'sd0, 0);
  endtask

  initial begin
    real    x;
    int     s0;
    longint tone_exp;
    longint d;
    int     ftw;
    longint y;
    int     sel;

    for (int k = 0; k < 256; k++) begin
      x = 8388607.0 * $sin(2.0 * 3.14159265358979323846 * k / 256.0);
      lut[k] = (x >= 0.0) ? longint'($rtoi($floor(x + 0.5))) : -longint'($rtoi($floor(-x + 0.5)));
    end
    tone_exp = (AMP * AMP) / 2;

    reset_n = 1'b0;
    bus.enable = 1'b0;
    bus.y_valid = 1'b0;
    bus.y_in = '0;
    bus.freq_tuning_word = '0;

    // Reset state
    step(1'b0, 1'b0, 1'b0, 64'sd0, 0);
    step(1'b1, 1'b0, 1'b0, 64'sd0, 0);
    chk("reset_state_count", 64'(strobes), 64'd0);
    idle(2);

    // DC, no rotation
    repeat (16) step(1'b1, 1'b1, 1'b1, DC_Y, 0);
    repeat (4) step(1'b1, 1'b1, 1'b0, 64'sd0, 0);
    chk("dc_strobes", 64'(strobes), 64'd1);
    chk("dc_latency", 64'(strobe_cyc - last_acc_cyc), 64'd3);
    chk("dc_i", 64'(obs_i), DC_EXP);
    chk("dc_q", 64'(obs_q), 64'sd0);
    idle(2);

    // Matched tone, two blocks with a valid gap between them
    s0 = strobes;
    for (int blk = 0; blk < 2; blk++) begin
      for (int k = 0; k < 16; k++) step(1'b1, 1'b1, 1'b1, lut[(16 * (blk * 16 + k) + 64) % 256], 16);
      repeat (4) step(1'b1, 1'b1, 1'b0, 64'sd0, 16);
      d = obs_i - tone_exp;
      chk("tone_i_tol", 64'(d <= TOL && d >= -TOL), 64'd1);
      chk("tone_q_tol", 64'(obs_q <= TOL && obs_q >= -TOL), 64'd1);
    end
    chk("tone_strobes", 64'(strobes - s0), 64'd2);
    idle(2);

    // Extremes
    repeat (16) step(1'b1, 1'b1, 1'b1, EXT_Y, 0);
    repeat (4) step(1'b1, 1'b1, 1'b0, 64'sd0, 0);
    chk("ext_i", 64'(obs_i), EXT_EXP);
    chk("ext_q", 64'(obs_q), 64'sd0);
    idle(2);

    // Valid gaps
    s0 = strobes;
    repeat (16) begin
      step(1'b1, 1'b1, 1'b1, DC_Y, 0);
      step(1'b1, 1'b1, 1'b0, 64'sd0, 0);
    end
    repeat (3) step(1'b1, 1'b1, 1'b0, 64'sd0, 0);
    chk("gap_strobes", 64'(strobes - s0), 64'd1);
    chk("gap_latency", 64'(strobe_cyc - last_acc_cyc), 64'd3);
    chk("gap_i", 64'(obs_i), DC_EXP);
    idle(2);

    // Abort mid-block (rotating phase), then a clean block
    s0 = strobes;
    repeat (10) step(1'b1, 1'b1, 1'b1, DC_Y, 16);
    idle(5);
    chk("abort_no_strobe", 64'(strobes - s0), 64'd0);
    step(1'b1, 1'b1, 1'b1, DC_Y, 0);
    step(1'b1, 1'b1, 1'b1, DC_Y, 0);
    chk("abort_qcar_restart", 64'(bus.q_carrier), 64'sd0);
    chk("abort_icar_restart", 64'(bus.i_carrier), AMP);
    repeat (14) step(1'b1, 1'b1, 1'b1, DC_Y, 0);
    repeat (4) step(1'b1, 1'b1, 1'b0, 64'sd0, 0);
    chk("abort_strobes", 64'(strobes - s0), 64'd1);
    chk("abort_i", 64'(obs_i), DC_EXP);
    idle(2);

    // Reset mid-block
    s0 = strobes;
    repeat (7) step(1'b1, 1'b1, 1'b1, DC_Y, 37);
    step(1'b0, 1'b1, 1'b1, DC_Y, 0);
    step(1'b1, 1'b1, 1'b1, DC_Y, 0);
    chk("rst_i_out", 64'(bus.i_out), 64'sd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_icar", 64'(bus.i_carrier), AMP);
    chk("rst_qcar", 64'(bus.q_carrier), 64'sd0);
    repeat (15) step(1'b1, 1'b1, 1'b1, DC_Y, 0);
    repeat (4) step(1'b1, 1'b1, 1'b0, 64'sd0, 0);
    chk("rst_block_strobes", 64'(strobes - s0), 64'd1);
    chk("rst_block_i", 64'(obs_i), DC_EXP);
    idle(2);

    // Randomized traffic against the model
    s0 = strobes;
    ftw = 0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 19) == 0) ftw = int'($urandom_range(0, 255));
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      y = EXT_Y;
      else if (sel == 1) y = AMP;
      else               y = longint'($urandom_range(0, 16777215)) - 64'sd8388608;
      step(($urandom_range(0, 299) != 0), ($urandom_range(0, 49) != 0),
           ($urandom_range(0, 3) != 0), y, ftw);
    end
    repeat (5) step(1'b1, 1'b1, 1'b0, 64'sd0, ftw);
    chk("random_strobes_seen", 64'(strobes > s0 + 10), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
